// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode/issue stage between register-file read (ID) and the ALU (EX).
//   Decodes a MIPS instruction into the 4-bit ALU control code, selects SrcAE/SrcBE and
//   registers the writeback/memory/branch controls behind a 2-entry buffer (OUT + SKID).
// Ports:
//   CLK, rst_n              clock, asynchronous active-low reset
//   InstrD, RD1D, RD2D      instruction word and rs/rt read data from ID
//   validD / readyD         ID-side handshake (readyD is registered: !SKID.valid)
//   FlushE                  drops every buffered instruction and any instruction offered this cycle
//   validE / readyE         EX-side handshake
//   ALUControlE, SrcAE, SrcBE, RegWriteE, WriteRegE, MemReadE, MemWriteE, BranchE, IllegalE
// Configuration macro: ALU_ISSUE_VSHIFT_EN enables sllv/srlv/srav (funct 04/06/07).
module alu_issue_stage #(
  parameter int unsigned DW  = 32,
  parameter int unsigned RAW = 5
) (
  input  logic           CLK,
  input  logic           rst_n,
  input  logic [31:0]    InstrD,
  input  logic [DW-1:0]  RD1D,
  input  logic [DW-1:0]  RD2D,
  input  logic           validD,
  output logic           readyD,
  input  logic           FlushE,
  input  logic           readyE,
  output logic           validE,
  output logic [3:0]     ALUControlE,
  output logic [DW-1:0]  SrcAE,
  output logic [DW-1:0]  SrcBE,
  output logic           RegWriteE,
  output logic [RAW-1:0] WriteRegE,
  output logic           MemReadE,
  output logic           MemWriteE,
  output logic           BranchE,
  output logic           IllegalE
);

  typedef struct packed {
    logic [3:0]     alu;
    logic [DW-1:0]  srca;
    logic [DW-1:0]  srcb;
    logic           reg_write;
    logic [RAW-1:0] write_reg;
    logic           mem_read;
    logic           mem_write;
    logic           branch;
    logic           illegal;
  } issue_t;

  logic [5:0]     w_op;
  logic [5:0]     w_funct;
  logic [4:0]     w_shamt;
  logic [RAW-1:0] w_rt;
  logic [RAW-1:0] w_rd;
  logic [DW-1:0]  w_simm;
  issue_t         w_dec;

  assign w_op    = InstrD[31:26];
  assign w_funct = InstrD[5:0];
  assign w_shamt = InstrD[10:6];
  assign w_rt    = InstrD[20:16];
  assign w_rd    = InstrD[15:11];
  assign w_simm  = {{(DW-16){InstrD[15]}}, InstrD[15:0]};

  always_comb begin
    w_dec           = '0;
    w_dec.alu       = 4'b0010;
    w_dec.illegal   = 1'b0;
    if (w_op == 6'h00) begin
      w_dec.srca      = RD1D;
      w_dec.srcb      = RD2D;
      w_dec.reg_write = 1'b1;
      w_dec.write_reg = w_rd;
      case (w_funct)
        6'h20, 6'h21: w_dec.alu = 4'b0010;
        6'h22, 6'h23: w_dec.alu = 4'b0110;
        6'h24:        w_dec.alu = 4'b0000;
        6'h25:        w_dec.alu = 4'b0001;
        6'h26:        w_dec.alu = 4'b0011;
        6'h27:        w_dec.alu = 4'b1100;
        6'h2A:        w_dec.alu = 4'b0111;
        6'h00: begin w_dec.alu = 4'b0100; w_dec.srca = DW'(w_shamt); end
        6'h02: begin w_dec.alu = 4'b0101; w_dec.srca = DW'(w_shamt); end
        6'h03: begin w_dec.alu = 4'b1000; w_dec.srca = DW'(w_shamt); end
`ifdef ALU_ISSUE_VSHIFT_EN
        6'h04: begin w_dec.alu = 4'b0100; w_dec.srca = DW'(RD1D[4:0]); end
        6'h06: begin w_dec.alu = 4'b0101; w_dec.srca = DW'(RD1D[4:0]); end
        6'h07: begin w_dec.alu = 4'b1000; w_dec.srca = DW'(RD1D[4:0]); end
`endif
        default:      w_dec.illegal = 1'b1;
      endcase
    end else begin
      w_dec.srca      = RD1D;
      w_dec.srcb      = w_simm;
      w_dec.reg_write = 1'b1;
      w_dec.write_reg = w_rt;
      case (w_op)
        6'h08, 6'h09: w_dec.alu = 4'b0010;
        6'h0A:        w_dec.alu = 4'b0111;
        6'h0C:        w_dec.alu = 4'b1111;  // ALU zero-extends the immediate itself
        6'h0D:        w_dec.alu = 4'b1101;
        6'h0E:        w_dec.alu = 4'b1110;
        6'h23: begin w_dec.alu = 4'b0010; w_dec.mem_read = 1'b1; end
        6'h2B: begin w_dec.alu = 4'b0010; w_dec.mem_write = 1'b1; w_dec.reg_write = 1'b0; end
        6'h04, 6'h05: begin
          w_dec.alu       = (w_op == 6'h04) ? 4'b1001 : 4'b1010;
          w_dec.srcb      = RD2D;
          w_dec.branch    = 1'b1;
          w_dec.reg_write = 1'b0;
        end
        default:      w_dec.illegal = 1'b1;
      endcase
    end
    if (w_dec.illegal) begin
      w_dec           = '0;
      w_dec.alu       = 4'b0010;
      w_dec.illegal   = 1'b1;
    end
    if (w_dec.write_reg == '0) begin
      w_dec.reg_write = 1'b0;
    end
  end

  // Two-entry buffer: OUT drives the E outputs, SKID catches an accept while OUT is stalled.
  issue_t r_out;
  issue_t r_skid;
  logic   r_out_valid;
  logic   r_skid_valid;
  logic   w_accept;
  logic   w_out_load;

  assign readyD     = !r_skid_valid;
  assign w_accept   = validD && !r_skid_valid;
  // OUT may take new content when it is empty or being consumed this cycle.
  assign w_out_load = !r_out_valid || readyE;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out        <= '0;
      r_skid       <= '0;
    end else if (FlushE) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_load) begin
      // SKID is always older than anything offered now; accept is blocked while it is full.
      r_out_valid  <= r_skid_valid || w_accept;
      r_skid_valid <= 1'b0;
      if (r_skid_valid) begin
        r_out <= r_skid;
      end else if (w_accept) begin
        r_out <= w_dec;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid       <= w_dec;
    end
  end

  assign validE      = r_out_valid;
  assign ALUControlE = r_out.alu;
  assign SrcAE       = r_out.srca;
  assign SrcBE       = r_out.srcb;
  assign RegWriteE   = r_out.reg_write;
  assign WriteRegE   = r_out.write_reg;
  assign MemReadE    = r_out.mem_read;
  assign MemWriteE   = r_out.mem_write;
  assign BranchE     = r_out.branch;
  assign IllegalE    = r_out.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: stimulus pushes mnemonic-level expected results,
// a negedge monitor pops and compares whenever EX consumes an instruction.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [3:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    logic        rw;
    logic [4:0]  wr;
    logic        mr;
    logic        mw;
    logic        br;
    logic        ill;
  } exp_t;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] InstrD = '0;
  logic [31:0] RD1D = '0;
  logic [31:0] RD2D = '0;
  logic        validD = 1'b0;
  logic        readyD;
  logic        FlushE = 1'b0;
  logic        readyE = 1'b0;
  logic        validE;
  logic [3:0]  ALUControlE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        RegWriteE;
  logic [4:0]  WriteRegE;
  logic        MemReadE;
  logic        MemWriteE;
  logic        BranchE;
  logic        IllegalE;

  int   checks = 0;
  int   errors = 0;
  int   n_push = 0;
  exp_t sb_q[$];
  logic mon_stalled = 1'b0;
  exp_t mon_prev;

  alu_issue_stage #(.DW(32), .RAW(5)) dut (
    .CLK(CLK), .rst_n(rst_n), .InstrD(InstrD), .RD1D(RD1D), .RD2D(RD2D),
    .validD(validD), .readyD(readyD), .FlushE(FlushE), .readyE(readyE), .validE(validE),
    .ALUControlE(ALUControlE), .SrcAE(SrcAE), .SrcBE(SrcBE), .RegWriteE(RegWriteE),
    .WriteRegE(WriteRegE), .MemReadE(MemReadE), .MemWriteE(MemWriteE), .BranchE(BranchE),
    .IllegalE(IllegalE)
  );

  always #5 CLK = ~CLK;

  function automatic exp_t dut_out();
    exp_t o;
    o = '{alu: ALUControlE, a: SrcAE, b: SrcBE, rw: RegWriteE, wr: WriteRegE,
          mr: MemReadE, mw: MemWriteE, br: BranchE, ill: IllegalE};
    return o;
  endfunction

  // Reference: name the instruction, then derive each output from that name.
  function automatic exp_t model(logic [31:0] ins, logic [31:0] a, logic [31:0] b);
    exp_t        e;
    string       m;
    logic [31:0] simm;
    simm = {{16{ins[15]}}, ins[15:0]};
    m = "ill";
    if (ins[31:26] == 6'h00) begin
      case (ins[5:0])
        6'h20, 6'h21: m = "add";
        6'h22, 6'h23: m = "sub";
        6'h24: m = "and";
        6'h25: m = "or";
        6'h26: m = "xor";
        6'h27: m = "nor";
        6'h2A: m = "slt";
        6'h00: m = "sll";
        6'h02: m = "srl";
        6'h03: m = "sra";
`ifdef ALU_ISSUE_VSHIFT_EN
        6'h04: m = "sllv";
        6'h06: m = "srlv";
        6'h07: m = "srav";
`endif
        default: m = "ill";
      endcase
    end else begin
      case (ins[31:26])
        6'h08, 6'h09: m = "addi";
        6'h0A: m = "slti";
        6'h0C: m = "andi";
        6'h0D: m = "ori";
        6'h0E: m = "xori";
        6'h23: m = "lw";
        6'h2B: m = "sw";
        6'h04: m = "beq";
        6'h05: m = "bne";
        default: m = "ill";
      endcase
    end
    e = '0;
    case (m)
      "add", "sub", "and", "or", "xor", "nor", "slt": begin
        e.a = a; e.b = b; e.rw = 1'b1; e.wr = ins[15:11];
      end
      "sll", "srl", "sra": begin
        e.a = {27'b0, ins[10:6]}; e.b = b; e.rw = 1'b1; e.wr = ins[15:11];
      end
      "sllv", "srlv", "srav": begin
        e.a = {27'b0, a[4:0]}; e.b = b; e.rw = 1'b1; e.wr = ins[15:11];
      end
      "addi", "slti", "andi", "ori", "xori": begin
        e.a = a; e.b = simm; e.rw = 1'b1; e.wr = ins[20:16];
      end
      "lw":  begin e.a = a; e.b = simm; e.rw = 1'b1; e.mr = 1'b1; e.wr = ins[20:16]; end
      "sw":  begin e.a = a; e.b = simm; e.mw = 1'b1; e.wr = ins[20:16]; end
      "beq", "bne": begin e.a = a; e.b = b; e.br = 1'b1; e.wr = ins[20:16]; end
      default: e.ill = 1'b1;
    endcase
    case (m)
      "and": e.alu = 4'h0;   "or": e.alu = 4'h1;   "xor": e.alu = 4'h3;
      "sub": e.alu = 4'h6;   "nor": e.alu = 4'hC;
      "slt", "slti": e.alu = 4'h7;
      "sll", "sllv": e.alu = 4'h4;
      "srl", "srlv": e.alu = 4'h5;
      "sra", "srav": e.alu = 4'h8;
      "beq": e.alu = 4'h9;   "bne": e.alu = 4'hA;
      "andi": e.alu = 4'hF;  "ori": e.alu = 4'hD;  "xori": e.alu = 4'hE;
      default: e.alu = 4'h2;  // add, addi, lw, sw, illegal
    endcase
    if (e.wr == 5'd0) e.rw = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          k;
    logic [5:0]  f;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k == 0) return r;
    if (k < 5) begin
      case ($urandom_range(0, 14))
        0: f = 6'h20;  1: f = 6'h21;  2: f = 6'h22;  3: f = 6'h23;  4: f = 6'h24;
        5: f = 6'h25;  6: f = 6'h26;  7: f = 6'h27;  8: f = 6'h2A;  9: f = 6'h00;
        10: f = 6'h02; 11: f = 6'h03; 12: f = 6'h04; 13: f = 6'h06; default: f = 6'h07;
      endcase
      return {6'h00, r[25:6], f};
    end
    case ($urandom_range(0, 9))
      0: f = 6'h08; 1: f = 6'h09; 2: f = 6'h0A; 3: f = 6'h0C; 4: f = 6'h0D;
      5: f = 6'h0E; 6: f = 6'h23; 7: f = 6'h2B; 8: f = 6'h04; default: f = 6'h05;
    endcase
    return {f, r[25:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // One cycle of stimulus; the expected result is queued once the accept condition is known.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] a,
                     input logic [31:0] b, input logic re, input logic fl);
    @(posedge CLK);
    #1;
    validD = v; InstrD = ins; RD1D = a; RD2D = b; readyE = re; FlushE = fl;
    @(negedge CLK);
    #1;
    if (v && readyD && !fl) begin
      sb_q.push_back(model(ins, a, b));
      n_push++;
    end
  endtask

  // Monitor: queue state at each negedge mirrors the DUT's OUT/SKID occupancy.
  always @(negedge CLK) begin
    if (!rst_n) begin
      mon_stalled <= 1'b0;
    end else begin
      exp_t act;
      exp_t req;
      act = dut_out();
      chk("validE_occupancy", 32'(validE), 32'(sb_q.size() != 0));
      chk("readyD_occupancy", 32'(readyD), 32'(sb_q.size() < 2));
      if (mon_stalled) begin
        checks++;
        if (act !== mon_prev) begin
          errors++;
          $display("FAIL stall_stable: got %h expected %h", act, mon_prev);
        end
      end
      if (FlushE) begin
        sb_q.delete();
      end else if (validE && readyE && sb_q.size() != 0) begin
        req = sb_q.pop_front();
        if (req.ill) begin
          act.wr = '0;
          req.wr = '0;
        end
        checks++;
        if (act !== req) begin
          errors++;
          $display("FAIL issue_pop: got %h expected %h", act, req);
        end
      end
      mon_stalled <= validE && !readyE && !FlushE;
      mon_prev    <= dut_out();
    end
  end

  initial begin
    int base;
    #12;
    chk("rst_validE", 32'(validE), 32'd0);
    chk("rst_outputs", {ALUControlE, RegWriteE, WriteRegE, MemReadE, MemWriteE, BranchE,
                        IllegalE}, 32'd0);
    chk("rst_srca", SrcAE, 32'd0);
    @(negedge CLK);
    #2 rst_n = 1'b1;
    #1 chk("rst_readyD", 32'(readyD), 32'd1);

    // add $8,$9,$10
    cyc(1'b1, 32'h012A4020, 32'd5, 32'd7, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("add_valid", 32'(validE), 32'd1);
    chk("add_alu", 32'(ALUControlE), 32'h2);
    chk("add_srca", SrcAE, 32'd5);
    chk("add_srcb", SrcBE, 32'd7);
    chk("add_wr", 32'(WriteRegE), 32'd8);
    chk("add_rw", 32'(RegWriteE), 32'd1);

    // sra $8,$9,2
    cyc(1'b1, 32'h00094083, 32'h0, 32'hF0000000, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("sra_alu", 32'(ALUControlE), 32'h8);
    chk("sra_srca", SrcAE, 32'd2);
    chk("sra_srcb", SrcBE, 32'hF0000000);

    // addi $8,$9,-1
    cyc(1'b1, 32'h2128FFFF, 32'd3, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("addi_alu", 32'(ALUControlE), 32'h2);
    chk("addi_srcb", SrcBE, 32'hFFFFFFFF);
    chk("addi_wr", 32'(WriteRegE), 32'd8);
    chk("addi_rw", 32'(RegWriteE), 32'd1);

    // funct 0x04 (sllv $8,$10,$9)
    cyc(1'b1, 32'h012A4004, 32'h23, 32'h55, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
`ifdef ALU_ISSUE_VSHIFT_EN
    chk("sllv_alu", 32'(ALUControlE), 32'h4);
    chk("sllv_srca", SrcAE, 32'd3);
`else
    chk("f04_illegal", 32'(IllegalE), 32'd1);
    chk("f04_rw", 32'(RegWriteE), 32'd0);
`endif
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Backpressure: three back-to-back, only two fit.
    base = n_push;
    cyc(1'b1, 32'h012A4020, 32'd1, 32'd2, 1'b0, 1'b0);
    cyc(1'b1, 32'h012A4022, 32'd3, 32'd4, 1'b0, 1'b0);
    cyc(1'b1, 32'h012A4024, 32'd5, 32'd6, 1'b0, 1'b0);
    chk("bp_accepted", 32'(n_push - base), 32'd2);
    chk("bp_readyD", 32'(readyD), 32'd0);
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("bp_drained", 32'(validE), 32'd0);

    // Flush with both entries full and a third offered.
    cyc(1'b1, 32'h2128FFFF, 32'd1, 32'd2, 1'b0, 1'b0);
    cyc(1'b1, 32'h8D280004, 32'd3, 32'd4, 1'b0, 1'b0);
    cyc(1'b1, 32'h012A4020, 32'd5, 32'd6, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("flush_validE", 32'(validE), 32'd0);
    chk("flush_readyD", 32'(readyD), 32'd1);

    // Reset in the middle of a transfer discards both entries.
    cyc(1'b1, 32'h012A4020, 32'd1, 32'd2, 1'b0, 1'b0);
    cyc(1'b1, 32'h012A4025, 32'd3, 32'd4, 1'b0, 1'b0);
    validD = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("midrst_validE", 32'(validE), 32'd0);
    chk("midrst_alu", 32'(ALUControlE), 32'd0);
    sb_q.delete();
    @(negedge CLK);
    #2 rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom,
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0));
    end

    // Bounded drain.
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    chk("final_drain", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
